// File: rtl/fp_recip_seq_if.sv
// Handshake and data bundle for the FP32 reciprocal unit.
// master: operand producer / result consumer. slave: the reciprocal unit.
interface fp_recip_seq_if;
    logic        i_valid;
    logic [31:0] i_operand;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_dz;
    logic        o_uf;
    logic        i_ready;

    modport master (
        output i_valid, i_operand, i_ready,
        input  o_ready, o_valid, o_result, o_dz, o_uf
    );

    modport slave (
        input  i_valid, i_operand, i_ready,
        output o_ready, o_valid, o_result, o_dz, o_uf
    );
endinterface

// File: rtl/fp_recip_seq.sv
// Multi-cycle FP32 reciprocal (1/x). A restoring divider produces one quotient bit per cycle;
// denormals are flushed to zero, and results with too small an exponent are flushed to signed zero.
module fp_recip_seq #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23
) (
    input logic           i_clk,
    input logic           i_rst_n,
    fp_recip_seq_if.slave bus
);
    localparam int unsigned OP_W  = 1 + EXP_W + MANT_W;
    localparam int unsigned Q_W   = MANT_W + 2;
    localparam int unsigned CNT_W = $clog2(Q_W);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    // Biased exponents at or above these give a true result exponent <= 0.
    localparam logic [EXP_W-1:0] EXP_LIM0 = EXP_W'(2 ** EXP_W - 2);
    localparam logic [EXP_W-1:0] EXP_LIM1 = EXP_W'(2 ** EXP_W - 3);
    localparam logic [OP_W-1:0]  QNAN     = OP_W'(32'h7FC0_0000);

    typedef enum logic [1:0] {StIdle, StDiv, StPack, StDone} state_e;

    state_e               state_q, state_d;
    logic                 sign_q, sign_d;
    logic [EXP_W-1:0]     exp_q, exp_d;
    logic [MANT_W-1:0]    mant_q, mant_d;
    logic [Q_W-1:0]       rem_q, rem_d;
    logic [Q_W-1:0]       quot_q, quot_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OP_W-1:0]      result_q, result_d;
    logic                 dz_q, dz_d;
    logic                 uf_q, uf_d;
    logic                 valid_q, valid_d;

    logic                 op_sign;
    logic [EXP_W-1:0]     op_exp;
    logic [MANT_W-1:0]    op_mant;
    logic [MANT_W:0]      divisor;
    logic [EXP_W:0]       inv_exp;
    logic                 offset;
    logic                 flush;
    logic [EXP_W-1:0]     new_exp;
    logic [MANT_W-1:0]    frac;

    assign op_sign = bus.i_operand[OP_W-1];
    assign op_exp  = bus.i_operand[OP_W-2:MANT_W];
    assign op_mant = bus.i_operand[MANT_W-1:0];

    assign divisor = {1'b1, mant_q};
    assign inv_exp = ~{1'b0, exp_q} + (EXP_W + 1)'(1);
    assign offset  = |mant_q;
    assign flush   = offset ? (exp_q >= EXP_LIM1) : (exp_q >= EXP_LIM0);
    // Q = 1<<24 for a power of two, otherwise the leading one sits at Q[23].
    assign frac    = quot_q[Q_W-1] ? quot_q[MANT_W:1] : quot_q[MANT_W-1:0];

    exponent_update #(
        .EXP_W (EXP_W)
    ) u_exponent_update (
        .i_inv_exponent (inv_exp),
        .i_offset       ({1'b0, offset}),
        .o_exponent     (new_exp)
    );

    assign bus.o_ready  = (state_q == StIdle);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_dz     = dz_q;
    assign bus.o_uf     = uf_q;

    // Next-state: operand classification, divider step, packing and output handshake.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dz_d     = dz_q;
        uf_d     = uf_q;
        valid_d  = valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    sign_d = op_sign;
                    exp_d  = op_exp;
                    mant_d = op_mant;
                    if (op_exp == '0) begin
                        result_d = {op_sign, EXP_ONES, {MANT_W{1'b0}}};
                        dz_d     = 1'b1;
                        state_d  = StDone;
                    end else if (op_exp == EXP_ONES) begin
                        result_d = (op_mant == '0) ? {op_sign, {(OP_W - 1){1'b0}}} : QNAN;
                        state_d  = StDone;
                    end else begin
                        rem_d   = Q_W'(1) << MANT_W;
                        quot_d  = '0;
                        cnt_d   = CNT_W'(Q_W - 1);
                        state_d = StDiv;
                    end
                end
            end
            StDiv: begin
                if (rem_q >= {1'b0, divisor}) begin
                    rem_d  = (rem_q - {1'b0, divisor}) << 1;
                    quot_d = {quot_q[Q_W-2:0], 1'b1};
                end else begin
                    rem_d  = rem_q << 1;
                    quot_d = {quot_q[Q_W-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = StPack;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StPack: begin
                uf_d     = flush;
                result_d = flush ? {sign_q, {(OP_W - 1){1'b0}}} : {sign_q, new_exp, frac};
                state_d  = StDone;
            end
            StDone: begin
                // o_valid rises one cycle after the result register is loaded.
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (bus.i_ready) begin
                    valid_d = 1'b0;
                    dz_d    = 1'b0;
                    uf_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                dz_d    = 1'b0;
                uf_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            uf_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            uf_q     <= uf_d;
            valid_q  <= valid_d;
        end
    end
endmodule

// Reciprocal exponent: (2*bias) - e - offset, with -e supplied in two's complement.
module exponent_update #(
    parameter int unsigned EXP_W = 8
) (
    input  logic [EXP_W:0]   i_inv_exponent,
    input  logic [1:0]       i_offset,
    output logic [EXP_W-1:0] o_exponent
);
    logic [EXP_W:0] sum;
    logic           unused_carry;

    // Wraps modulo 2^EXP_W; callers only use it when the result is in range.
    always_comb begin
        sum = i_inv_exponent + (EXP_W + 1)'(2 ** EXP_W - 2) - (EXP_W + 1)'(i_offset);
    end

    assign o_exponent   = sum[EXP_W-1:0];
    assign unused_carry = sum[EXP_W];
endmodule

// File: tb/tb_fp_recip_seq.sv
// Bench for fp_recip_seq: directed vector table, random operands against a reciprocal
// model, backpressure and mid-operation reset sequences.
module tb_fp_recip_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    fp_recip_seq_if bus ();

    fp_recip_seq dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
        logic        dz;
        logic        uf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // 1/x from the real value: x = M * 2^(e-150), so 1/x = (2^47/M) * 2^(103-e).
    function automatic void ref_recip(input logic [31:0] x, output logic [31:0] r,
                                      output logic dz, output logic uf, output int lat);
        logic   s;
        int     e;
        int     be;
        longint mv;
        longint q;
        s   = x[31];
        e   = int'(x[30:23]);
        dz  = 1'b0;
        uf  = 1'b0;
        lat = 1;
        if (e == 0) begin
            r  = {s, 8'hFF, 23'h0};
            dz = 1'b1;
        end else if (e == 255) begin
            r = (x[22:0] == 23'h0) ? {s, 31'h0} : 32'h7FC0_0000;
        end else begin
            lat = 27;
            mv  = longint'({1'b1, x[22:0]});
            q   = (longint'(1) << 47) / mv;
            be  = 127 + (103 - e) + 23;
            if (q >= (longint'(1) << 24)) begin
                q  = q >> 1;
                be = be + 1;
            end
            if (be <= 0) begin
                r  = {s, 31'h0};
                uf = 1'b1;
            end else begin
                r = {s, 8'(be), 23'(q)};
            end
        end
    endfunction

    task automatic send(input logic [31:0] op);
        int n;
        n = 0;
        bus.i_operand = op;
        bus.i_valid   = 1'b1;
        while (bus.o_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_ready", {31'h0, bus.o_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic get_result(output logic [31:0] res, output logic dz, output logic uf,
                              output int lat);
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.o_result;
        dz  = bus.o_dz;
        uf  = bus.o_uf;
        if (bus.i_ready === 1'b1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [31:0] op;
        logic [31:0] e_res;
        logic        dz;
        logic        uf;
        logic        e_dz;
        logic        e_uf;
        int          lat;
        int          e_lat;
        int          sel;
        int          stray;

        vecs.push_back(vec_t'{32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 27});
        vecs.push_back(vec_t'{32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 27});
        vecs.push_back(vec_t'{32'hC080_0000, 32'hBE80_0000, 1'b0, 1'b0, 27});
        vecs.push_back(vec_t'{32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0, 27});
        vecs.push_back(vec_t'{32'h8000_0000, 32'hFF80_0000, 1'b1, 1'b0, 1});
        vecs.push_back(vec_t'{32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1});
        vecs.push_back(vec_t'{32'h7FC1_2345, 32'h7FC0_0000, 1'b0, 1'b0, 1});
        vecs.push_back(vec_t'{32'hFFC0_0001, 32'h7FC0_0000, 1'b0, 1'b0, 1});
        vecs.push_back(vec_t'{32'h0000_0001, 32'h7F80_0000, 1'b1, 1'b0, 1});
        vecs.push_back(vec_t'{32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1, 27});
        vecs.push_back(vec_t'{32'h7E80_0001, 32'h0000_0000, 1'b0, 1'b1, 27});
        vecs.push_back(vec_t'{32'h7E80_0000, 32'h0080_0000, 1'b0, 1'b0, 27});

        bus.i_valid   = 1'b0;
        bus.i_operand = 32'h0;
        bus.i_ready   = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, bus.o_valid}, 32'h0);
        check("rst_result", bus.o_result, 32'h0);
        check("rst_dz", {31'h0, bus.o_dz}, 32'h0);
        check("rst_uf", {31'h0, bus.o_uf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'h0, bus.o_ready}, 32'h1);

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].op);
            get_result(res, dz, uf, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_dz", i), {31'h0, dz}, {31'h0, vecs[i].dz});
            check($sformatf("vec%0d_uf", i), {31'h0, uf}, {31'h0, vecs[i].uf});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_valid_clear", i), {31'h0, bus.o_valid}, 32'h0);
        end

        // Random operands against the model.
        for (int i = 0; i < 150; i++) begin
            op  = $urandom;
            sel = $urandom_range(0, 15);
            case (sel)
                0: op[30:23] = 8'h00;
                1: op[30:23] = 8'hFF;
                2: op[30:23] = 8'd253;
                3: op[30:23] = 8'd254;
                4: op[22:0]  = 23'h0;
                5: begin
                    op[30:23] = 8'd253;
                    op[22:0]  = 23'h0;
                end
                default: ;
            endcase
            ref_recip(op, e_res, e_dz, e_uf, e_lat);
            send(op);
            get_result(res, dz, uf, lat);
            check($sformatf("rnd%0d_result op=%h", i, op), res, e_res);
            check($sformatf("rnd%0d_flags op=%h", i, op), {30'h0, dz, uf}, {30'h0, e_dz, e_uf});
            check($sformatf("rnd%0d_latency op=%h", i, op), lat, e_lat);
        end

        // Backpressure: result held for 10 cycles while the producer already offers the next op.
        bus.i_ready = 1'b0;
        send(32'h4040_0000);
        bus.i_operand = 32'h4000_0000;
        bus.i_valid   = 1'b1;
        get_result(res, dz, uf, lat);
        check("bp_result", res, 32'h3EAA_AAAA);
        check("bp_latency", lat, 27);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_valid", c), {31'h0, bus.o_valid}, 32'h1);
            check($sformatf("bp_hold%0d_result", c), bus.o_result, 32'h3EAA_AAAA);
            check($sformatf("bp_hold%0d_ready", c), {31'h0, bus.o_ready}, 32'h0);
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'h0, bus.o_valid}, 32'h0);
        check("bp_release_ready", {31'h0, bus.o_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        get_result(res, dz, uf, lat);
        check("bp_next_result", res, 32'h3F00_0000);
        check("bp_next_latency", lat, 27);

        // Reset in the middle of a division.
        send(32'h4040_0000);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, bus.o_valid}, 32'h0);
        check("mid_rst_result", bus.o_result, 32'h0);
        check("mid_rst_flags", {30'h0, bus.o_dz, bus.o_uf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", {31'h0, bus.o_ready}, 32'h1);
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid === 1'b1) stray++;
        end
        check("mid_rst_no_stale_valid", stray, 0);
        send(32'h4000_0000);
        get_result(res, dz, uf, lat);
        check("mid_rst_next_result", res, 32'h3F00_0000);
        check("mid_rst_next_latency", lat, 27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
